// File: rtl/dm_responder.sv
// Data-memory responder: word-addressed RAM with byte/half/word access, a zeroing sweep
// after reset, and a one-deep registered response with valid/ready handshakes.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {StClear, StIdle, StResp} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic              w_oob;
  logic              w_err;
  logic              w_store;
  logic [31:0]       w_rword;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_wmerge;

  assign req_ready = (r_state == StIdle) || ((r_state == StResp) && rsp_ready);
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept = req_valid && req_ready;
  assign w_idx    = req_addr[ADDR_W+1:2];
  assign w_lane   = req_addr[1:0];
  assign w_oob    = |req_addr[31:ADDR_W+2];
  assign w_store  = w_accept && req_we && !w_err;

  always_comb begin
    w_err = 1'b0;
    case (req_op)
      3'b000:         w_err = |w_lane;
      3'b001, 3'b010: w_err = w_lane[0];
      3'b011, 3'b100: w_err = 1'b0;
      default:        w_err = 1'b1;
    endcase
    if (w_oob) w_err = 1'b1;
  end

  // Asynchronous read so a load right after a store sees the freshly written word.
  assign w_rword = r_mem[w_idx];
  assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_byte  = w_rword[8*w_lane +: 8];

  always_comb begin
    w_load = '0;
    case (req_op)
      3'b000:  w_load = w_rword;
      3'b001:  w_load = {16'h0000, w_half};
      3'b010:  w_load = {{16{w_half[15]}}, w_half};
      3'b011:  w_load = {24'h000000, w_byte};
      3'b100:  w_load = {{24{w_byte[7]}}, w_byte};
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = '0;
    case (req_op)
      3'b000: begin
        w_be     = 4'b1111;
        w_wlanes = req_wdata;
      end
      3'b001, 3'b010: begin
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      3'b011, 3'b100: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{req_wdata[7:0]}};
      end
      default: begin
        w_be     = 4'b0000;
        w_wlanes = '0;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      w_wmerge[8*i +: 8] = w_be[i] ? w_wlanes[8*i +: 8] : w_rword[8*i +: 8];
    end
  end

  // Storage is not reset; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (r_state == StClear) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_store) begin
      r_mem[w_idx] <= w_wmerge;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        StClear: begin
          r_clr_idx <= r_clr_idx + ADDR_W'(1);
          if (r_clr_idx == ADDR_W'(DEPTH_WORDS - 1)) r_state <= StIdle;
        end
        StIdle, StResp: begin
          if (w_accept) begin
            r_state <= StResp;
            r_rdata <= (req_we || w_err) ? 32'h0 : w_load;
            r_err   <= w_err;
          end else if ((r_state == StResp) && rsp_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Randomised bench for dm_responder against a byte-addressed little-endian memory model.
module tb_dm_responder;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_m [4*Depth];

  dm_responder #(.DEPTH_WORDS(Depth), .ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 4 * Depth; i++) mem_m[i] = 8'h00;
  endfunction

  function automatic void model_access(input logic we, input logic [2:0] op,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic er);
    int unsigned size;
    logic [31:0] v;
    size = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : 1;
    er = (op > 3'd4) || (addr >= 32'(4 * Depth)) || ((addr % size) != 0);
    rd = '0;
    if (er) return;
    if (we) begin
      for (int k = 0; k < int'(size); k++) mem_m[int'(addr) + k] = wdata[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < int'(size); k++) v = v | ({24'h0, mem_m[int'(addr) + k]} << (8 * k));
      if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
      if (op == 3'd4 && v[7])  v = v | 32'hFFFF_FF00;
      rd = v;
    end
  endfunction

  // One request with a single-cycle response consumed immediately; returns what was observed.
  task automatic xact(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                      output logic vld);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vld = rsp_valid; rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_clear(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!req_ready && cycles < 3000);
  endtask

  task automatic test_reset();
    int cyc;
    logic [31:0] rd;
    logic er, vld;
    reset = 1'b0;
    #23;
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rr=%b rv=%b rd=%h er=%b, want 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    wait_clear(cyc);
    n_checks++;
    if (cyc != Depth) begin
      n_errors++;
      $display("FAIL clear_latency: req_ready after %0d cycles, want %0d", cyc, Depth);
    end
    xact(1'b0, 3'd0, 32'h0, 32'h0, rd, er, vld);
    n_checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL first_load: got v=%b rd=%h er=%b, want 1 00000000 0", vld, rd, er);
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd, ed;
    logic er, ee, vld;
    logic [2:0]  ops  [4] = '{3'd4, 3'd3, 3'd2, 3'd1};
    logic [31:0] adrs [4] = '{32'h13, 32'h11, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
    xact(1'b1, 3'd0, 32'h10, 32'h80FF_7F01, rd, er, vld);
    model_access(1'b1, 3'd0, 32'h10, 32'h80FF_7F01, ed, ee);
    n_checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL store_rsp: got v=%b rd=%h er=%b, want 1 00000000 0", vld, rd, er);
    end
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, ops[i], adrs[i], 32'h0, rd, er, vld);
      n_checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        n_errors++;
        $display("FAIL extend_load op=%0d @%h: got %h err=%b, want %h err=0",
                 ops[i], adrs[i], rd, er, exps[i]);
      end
    end
    xact(1'b1, 3'd0, 32'h20, 32'h1122_3344, rd, er, vld);
    model_access(1'b1, 3'd0, 32'h20, 32'h1122_3344, ed, ee);
    xact(1'b1, 3'd3, 32'h21, 32'h0000_00AA, rd, er, vld);
    model_access(1'b1, 3'd3, 32'h21, 32'h0000_00AA, ed, ee);
    xact(1'b0, 3'd0, 32'h20, 32'h0, rd, er, vld);
    n_checks++;
    if (rd !== 32'h1122_AA44) begin
      n_errors++;
      $display("FAIL byte_store: got %h, want 1122aa44", rd);
    end
    xact(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, rd, er, vld);
    model_access(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, ed, ee);
    xact(1'b0, 3'd0, 32'h20, 32'h0, rd, er, vld);
    n_checks++;
    if (rd !== 32'hBEEF_AA44) begin
      n_errors++;
      $display("FAIL half_store: got %h, want beefaa44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ed;
    logic er, ee, vld;
    logic        wes  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd0, 3'd7};
    logic [31:0] adrs [4] = '{32'h002, 32'h005, 32'h1000, 32'h040};
    logic [31:0] chk  [4] = '{32'h000, 32'h004, 32'h000, 32'h040};
    for (int i = 0; i < 4; i++) begin
      xact(wes[i], ops[i], adrs[i], 32'hDEAD_BEEF, rd, er, vld);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        n_errors++;
        $display("FAIL err_flag #%0d: got err=%b rd=%h, want 1 00000000", i, er, rd);
      end
      xact(1'b0, 3'd0, chk[i], 32'h0, rd, er, vld);
      model_access(1'b0, 3'd0, chk[i], 32'h0, ed, ee);
      n_checks++;
      if (rd !== ed || er !== 1'b0) begin
        n_errors++;
        $display("FAIL err_nowrite #%0d @%h: got %h, want %h", i, chk[i], rd, ed);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held, ed, sv;
    logic ee;
    logic [31:0] rd;
    logic er, vld;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    held = rsp_rdata;
    model_access(1'b0, 3'd0, 32'h10, 32'h0, ed, ee);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ed || req_ready !== 1'b0 || rsp_rdata !== held) begin
        n_errors++;
        $display("FAIL stall_hold c=%0d: got v=%b rd=%h rr=%b, want 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, ed);
      end
    end
    sv = $urandom;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'd0; req_addr = 32'h30; req_wdata = sv;
    model_access(1'b1, 3'd0, 32'h30, sv, ed, ee);
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_store: got v=%b rd=%h er=%b, want 1 00000000 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    req_we = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== sv || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_load: got v=%b rd=%h, want 1 %h", rsp_valid, rsp_rdata, sv);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle: got rsp_valid=%b, want 0", rsp_valid);
    end
    xact(1'b0, 3'd0, 32'h30, 32'h0, rd, er, vld);
    n_checks++;
    if (rd !== sv) begin
      n_errors++;
      $display("FAIL b2b_persist: got %h, want %h", rd, sv);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ed, a, wd;
    logic er, ee, vld, we;
    logic [2:0] op;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 2) != 0) a = (op == 3'd0) ? (a & ~32'h3) : (a & ~32'h1);
      wd = $urandom;
      model_access(we, op, a, wd, ed, ee);
      xact(we, op, a, wd, rd, er, vld);
      n_checks++;
      if (vld !== 1'b1 || rd !== ed || er !== ee) begin
        n_errors++;
        $display("FAIL random #%0d we=%b op=%0d @%h: got v=%b rd=%h er=%b, want 1 %h %b",
                 n, we, op, a, vld, rd, er, ed, ee);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [31:0] rd, ed;
    logic er, ee, vld;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h20; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: got v=%b rr=%b rd=%h er=%b, want 0 0 0 0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    wait_clear(cyc);
    n_checks++;
    if (cyc != Depth) begin
      n_errors++;
      $display("FAIL reclear_latency: req_ready after %0d cycles, want %0d", cyc, Depth);
    end
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, 3'd0, 32'(i * 4), 32'h0, rd, er, vld);
      model_access(1'b0, 3'd0, 32'(i * 4), 32'h0, ed, ee);
      n_checks++;
      if (rd !== ed || er !== ee) begin
        n_errors++;
        $display("FAIL reclear_read @%h: got %h, want %h", i * 4, rd, ed);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit memory words (power of two, 16..4096).
REQ-002 SHALL have parameter ADDR_W, default 10, word-index width, equal to log2(DEPTH_WORDS).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 SHALL have port req_valid  input  1  request present from the memory stage.
REQ-006 SHALL have port req_ready  output  1  request accepted on a cycle where req_valid && req_ready.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_op  input  3  000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; stores ignore signedness.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed on a cycle where rsp_valid && rsp_ready.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended per req_op; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned, out of range, or had illegal req_op.

Function
REQ-015 SHALL implement states CLEAR, IDLE, RESP.
REQ-016 CLEAR: SHALL write 0 to one word per cycle, index 0 upward; after index DEPTH_WORDS-1 SHALL go to IDLE; req_ready=0 throughout.
REQ-017 IDLE: req_ready=1, rsp_valid=0; on accept SHALL register the response and go to RESP next cycle (latency exactly 1 cycle).
REQ-018 RESP: rsp_valid=1; outputs SHALL hold stable until rsp_ready=1.
REQ-019 RESP: req_ready SHALL equal rsp_ready; an accept in the same cycle as the response is consumed SHALL keep the state at RESP with the new response next cycle (back-to-back, one request per cycle).
REQ-020 RESP with rsp_ready=1 and no new accept SHALL go to IDLE.
REQ-021 Word index SHALL be req_addr[ADDR_W+1:2]; byte lane SHALL be req_addr[1:0].
REQ-022 Error SHALL be flagged when: word op with addr[1:0]!=0; half op with addr[0]!=0; req_addr >= 4*DEPTH_WORDS; req_op > 100.
REQ-023 Errored store SHALL NOT modify memory; errored request SHALL give rsp_rdata=0, rsp_err=1.
REQ-024 Store SHALL update only the addressed bytes on the accept edge: word all 4 lanes; half lanes {addr[1],0} and {addr[1],1} from wdata[15:0]; byte lane addr[1:0] from wdata[7:0].
REQ-025 Store response SHALL be rsp_rdata=0, rsp_err=0.
REQ-026 Load SHALL read the memory word at the accept edge, select the half/byte by lane, and zero- or sign-extend to 32 bits per req_op.
REQ-027 A load accepted the cycle after a store to the same word SHALL return the updated data (no stale read).
REQ-028 Little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].

Reset
REQ-029 When reset=0, state SHALL go to CLEAR at once with clear index 0, independent of clk.
REQ-030 During reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-031 Reset during RESP or CLEAR SHALL drop the pending response and restart the clear sweep; memory SHALL read all zero once IDLE is reached.
REQ-032 The first accept SHALL be possible exactly DEPTH_WORDS cycles after reset rises (1024 at default).

Verification
REQ-033 Release reset, count cycles -> req_ready rises after 1024 cycles; load word @0x000 -> rsp_rdata=0x00000000, rsp_err=0.
REQ-034 Store word 0x80FF7F01 @0x010; load byte signed @0x013 -> 0xFFFFFF80; byte unsigned @0x011 -> 0x0000007F; half signed @0x012 -> 0xFFFF80FF; half unsigned @0x010 -> 0x00007F01.
REQ-035 Store byte 0xAA @0x021 over word 0x11223344 -> load word @0x020 -> 0x1122AA44; store half 0xBEEF @0x022 -> 0xBEEFAA44.
REQ-036 Misaligned load word @0x002, store half @0x005, any access @0x1000, req_op=111 -> each rsp_err=1, rsp_rdata=0; memory unchanged.
REQ-037 rsp_ready held 0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; then back-to-back store @0x030 followed by load @0x030 with rsp_ready=1 -> one response per cycle, load returns stored value.
REQ-038 Assert reset mid-RESP -> rsp_valid=0 immediately; after 1024 cycles of re-clear, previously written word @0x010 reads 0.
